// File: rtl/regfile_sb.sv
// regfile_sb: parametrised 2-read/1-write register file with a clear
// sequencer, same-cycle write-to-read bypass and a pending-write scoreboard
// for RAW stall detection at decode.
//
// Ports:
//   wrclk      single clock, all state updates on rising edge
//   rst_n      synchronous active-low reset
//   regwr      write enable (writeback)
//   rw, busW   write address / data
//   ra, rb     read addresses
//   busA, busB combinational read data
//   issue_vld  decode issues an instruction writing issue_rd
//   issue_rd   destination register of the issued instruction
//   busy_a/b   ra/rb has an outstanding write
//   init_busy  clear sequencer active, decode must not issue
module regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter logic        ZERO_REG = 1'b1,
  parameter logic        BYPASS   = 1'b1
) (
  input  logic            wrclk,
  input  logic            rst_n,
  input  logic            regwr,
  input  logic [AW-1:0]   rw,
  input  logic [XLEN-1:0] busW,
  input  logic [AW-1:0]   ra,
  input  logic [AW-1:0]   rb,
  output logic [XLEN-1:0] busA,
  output logic [XLEN-1:0] busB,
  input  logic            issue_vld,
  input  logic [AW-1:0]   issue_rd,
  output logic            busy_a,
  output logic            busy_b,
  output logic            init_busy
);

  localparam int unsigned NREG = 2 ** AW;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [AW-1:0]     cnt;
  logic [XLEN-1:0]   mem [NREG];
  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   pend_nxt;

  logic run;
  logic wr_zero;
  logic wr_en;
  logic byp_a;
  logic byp_b;

  assign run     = (state == RUN);
  assign wr_zero = ZERO_REG && (rw == '0);
  assign wr_en   = run && regwr && !wr_zero;

  // Bypass only forwards writes that will actually land in the array.
  assign byp_a = BYPASS && regwr && (rw == ra) && !wr_zero;
  assign byp_b = BYPASS && regwr && (rw == rb) && !wr_zero;

  // Clear first, then set: a same-index issue and writeback leaves the
  // newer writer outstanding.
  always_comb begin
    pend_nxt = pend;
    if (regwr)
      pend_nxt[rw] = 1'b0;
    if (issue_vld && !(ZERO_REG && (issue_rd == '0)))
      pend_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge wrclk) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      init_busy <= 1'b1;
      pend      <= '0;
    end else begin
      case (state)
        INIT: begin
          mem[cnt] <= '0;
          cnt      <= cnt + AW'(1);
          if (cnt == '1) begin
            state     <= RUN;
            init_busy <= 1'b0;
          end
        end
        RUN: begin
          if (wr_en)
            mem[rw] <= busW;
          pend <= pend_nxt;
        end
        default: begin
          state     <= INIT;
          cnt       <= '0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    busA = '0;
    if (run && !(ZERO_REG && (ra == '0)))
      busA = byp_a ? busW : mem[ra];
  end

  always_comb begin
    busB = '0;
    if (run && !(ZERO_REG && (rb == '0)))
      busB = byp_b ? busW : mem[rb];
  end

  assign busy_a = run && pend[ra] && !byp_a;
  assign busy_b = run && pend[rb] && !byp_b;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic        wrclk = 1'b0;
  always #5 wrclk = ~wrclk;

  // shared stimulus for dut0 (BYPASS=1) and dut1 (BYPASS=0)
  logic        rst_n, regwr, issue_vld;
  logic [4:0]  rw, ra, rb, issue_rd;
  logic [31:0] busW;
  logic [31:0] busA0, busB0, busA1, busB1;
  logic        busy_a0, busy_b0, init_busy0;
  logic        busy_a1, busy_b1, init_busy1;

  // dut2: XLEN=64, AW=3
  logic        rst2_n, regwr2, issue_vld2;
  logic [2:0]  rw2, ra2, rb2, issue_rd2;
  logic [63:0] busW2, busA2, busB2;
  logic        busy_a2, busy_b2, init_busy2;

  regfile_sb #(.XLEN(32), .AW(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut0 (
    .wrclk(wrclk), .rst_n(rst_n), .regwr(regwr), .rw(rw), .busW(busW),
    .ra(ra), .rb(rb), .busA(busA0), .busB(busB0), .issue_vld(issue_vld),
    .issue_rd(issue_rd), .busy_a(busy_a0), .busy_b(busy_b0), .init_busy(init_busy0));

  regfile_sb #(.XLEN(32), .AW(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut1 (
    .wrclk(wrclk), .rst_n(rst_n), .regwr(regwr), .rw(rw), .busW(busW),
    .ra(ra), .rb(rb), .busA(busA1), .busB(busB1), .issue_vld(issue_vld),
    .issue_rd(issue_rd), .busy_a(busy_a1), .busy_b(busy_b1), .init_busy(init_busy1));

  regfile_sb #(.XLEN(64), .AW(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut2 (
    .wrclk(wrclk), .rst_n(rst2_n), .regwr(regwr2), .rw(rw2), .busW(busW2),
    .ra(ra2), .rb(rb2), .busA(busA2), .busB(busB2), .issue_vld(issue_vld2),
    .issue_rd(issue_rd2), .busy_a(busy_a2), .busy_b(busy_b2), .init_busy(init_busy2));

  int checks = 0;
  int errors = 0;

  // reference model: register contents, pending set, remaining clear cycles
  logic [31:0] m_reg [32];
  bit          m_pend [32];
  int          m_init;
  bit          chk_en = 0;

  // values sampled at the last negedge
  logic [31:0] la0, lb0, la1;
  logic        lya0, lyb0, lib0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (m_init > 0 || a == 0) return 32'h0;
    if (byp && regwr && rw == a) return busW;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (m_init > 0) return 1'b0;
    return m_pend[a] && !(byp && regwr && rw == a);
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_init = 32;
      foreach (m_pend[i]) m_pend[i] = 0;
      chk_en = 1;
    end else if (chk_en) begin
      if (m_init > 0) begin
        m_reg[32 - m_init] = 32'h0;
        m_init--;
      end else begin
        if (regwr && rw != 0) m_reg[rw] = busW;
        if (regwr) m_pend[rw] = 0;
        if (issue_vld && issue_rd != 0) m_pend[issue_rd] = 1;
      end
    end
  endtask

  // one clock: check combinational outputs mid-cycle, then advance model
  task automatic cyc();
    @(negedge wrclk);
    la0 = busA0; lb0 = busB0; la1 = busA1;
    lya0 = busy_a0; lyb0 = busy_b0; lib0 = init_busy0;
    if (chk_en) begin
      chk("m_init_busy0", 64'(init_busy0), 64'(m_init > 0));
      chk("m_init_busy1", 64'(init_busy1), 64'(m_init > 0));
      chk("m_busA0", 64'(busA0), 64'(exp_rd(ra, 1)));
      chk("m_busB0", 64'(busB0), 64'(exp_rd(rb, 1)));
      chk("m_busA1", 64'(busA1), 64'(exp_rd(ra, 0)));
      chk("m_busB1", 64'(busB1), 64'(exp_rd(rb, 0)));
      chk("m_busy_a0", 64'(busy_a0), 64'(exp_busy(ra, 1)));
      chk("m_busy_b0", 64'(busy_b0), 64'(exp_busy(rb, 1)));
      chk("m_busy_a1", 64'(busy_a1), 64'(exp_busy(ra, 0)));
      chk("m_busy_b1", 64'(busy_b1), 64'(exp_busy(rb, 0)));
    end
    @(posedge wrclk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    regwr = 0; rw = 0; busW = 0; issue_vld = 0; issue_rd = 0;
  endtask

  // count cycles with init_busy high after release; bounded
  task automatic init_len(input string name, input int want, input bit deadwr);
    int n = 0;
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (deadwr && i < 20) begin
        regwr = 1; rw = 5; busW = 32'hDEAD; issue_vld = 1; issue_rd = 6;
      end else idle();
      cyc();
      if (lib0) n++; else done = 1;
    end
    chk(name, 64'(n), 64'(want));
  endtask

  typedef struct {
    logic [31:0] regwr, rw, busW, ra, rb, iv, ird;
    logic [31:0] ea, eb, eya, eyb, ea1;
  } vec_t;

  vec_t vecs [17];

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs = '{
      '{1, 3, 'h12345678, 1, 2, 0, 0,  0, 0, 0, 0, 0},
      '{0, 0, 0, 3, 0, 0, 0,  'h12345678, 0, 0, 0, 'h12345678},
      '{1, 0, 'hFFFFFFFF, 0, 3, 0, 0,  0, 'h12345678, 0, 0, 0},
      '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0},
      '{1, 7, 'hA5A5A5A5, 7, 7, 0, 0,  'hA5A5A5A5, 'hA5A5A5A5, 0, 0, 0},
      '{0, 0, 0, 7, 3, 0, 0,  'hA5A5A5A5, 'h12345678, 0, 0, 'hA5A5A5A5},
      '{0, 0, 0, 9, 9, 1, 9,  0, 0, 0, 0, 0},
      '{0, 0, 0, 9, 3, 0, 0,  0, 'h12345678, 1, 0, 0},
      '{1, 9, 'h99, 9, 9, 0, 0,  'h99, 'h99, 0, 0, 0},
      '{0, 0, 0, 9, 9, 0, 0,  'h99, 'h99, 0, 0, 'h99},
      '{1, 9, 'h1111, 5, 5, 1, 9,  0, 0, 0, 0, 0},
      '{0, 0, 0, 9, 9, 0, 0,  'h1111, 'h1111, 1, 1, 'h1111},
      '{0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0},
      '{1, 9, 'h2222, 0, 4, 1, 4,  0, 0, 0, 0, 0},
      '{0, 0, 0, 9, 4, 0, 0,  'h2222, 0, 0, 1, 'h2222},
      '{1, 4, 'h55, 4, 4, 1, 4,  'h55, 'h55, 0, 0, 0},
      '{0, 0, 0, 4, 4, 0, 0,  'h55, 'h55, 1, 1, 'h55}
    };

    rst_n = 0; idle(); ra = 0; rb = 0;
    rst2_n = 0; regwr2 = 0; rw2 = 0; busW2 = 0; ra2 = 0; rb2 = 0;
    issue_vld2 = 0; issue_rd2 = 0;

    // reset held 3 cycles, then clear sequence with ignored writes/issues
    repeat (3) cyc();
    chk("reset_init_busy", 64'(lib0), 64'(1));
    rst_n = 1;
    init_len("init_len_32", 32, 1);
    idle();
    for (int r = 0; r < 32; r++) begin
      ra = 5'(r); rb = 5'(31 - r);
      cyc();
      chk("reg_zero_after_init", 64'(la0), 64'(0));
    end
    ra = 5; rb = 6; cyc();
    chk("reg5_dead_ignored", 64'(la0), 64'(0));
    chk("reg6_not_pending", 64'(lyb0), 64'(0));

    // directed vectors
    foreach (vecs[i]) begin
      regwr = vecs[i].regwr[0]; rw = vecs[i].rw[4:0]; busW = vecs[i].busW;
      ra = vecs[i].ra[4:0]; rb = vecs[i].rb[4:0];
      issue_vld = vecs[i].iv[0]; issue_rd = vecs[i].ird[4:0];
      cyc();
      chk($sformatf("vec%0d_busA", i), 64'(la0), 64'(vecs[i].ea));
      chk($sformatf("vec%0d_busB", i), 64'(lb0), 64'(vecs[i].eb));
      chk($sformatf("vec%0d_busy_a", i), 64'(lya0), 64'(vecs[i].eya[0]));
      chk($sformatf("vec%0d_busy_b", i), 64'(lyb0), 64'(vecs[i].eyb[0]));
      chk($sformatf("vec%0d_busA_nobyp", i), 64'(la1), 64'(vecs[i].ea1));
    end
    idle();

    // reset in RUN with pend[4]=1, reg4=0x55, then again at cnt=10 of INIT
    ra = 4; rb = 4;
    rst_n = 0; cyc(); rst_n = 1;
    repeat (10) cyc();
    chk("mid_init_busy", 64'(lib0), 64'(1));
    rst_n = 0; cyc(); rst_n = 1;
    init_len("init_len_restart", 32, 0);
    ra = 4; rb = 4; cyc();
    chk("reg4_cleared", 64'(la0), 64'(0));
    chk("busy4_cleared", 64'(lya0), 64'(0));
    chk("init_busy_done", 64'(lib0), 64'(0));

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      regwr     = 1'($urandom_range(0, 1));
      rw        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      busW      = $urandom;
      ra        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rb        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      issue_vld = 1'($urandom_range(0, 1));
      issue_rd  = 5'($urandom_range(0, 7));
      cyc();
    end
    rst_n = 1; idle();

    // XLEN=64, AW=3 instance
    begin
      int n = 0;
      bit done = 0;
      @(negedge wrclk); rst2_n = 0;
      @(posedge wrclk); #1;
      @(posedge wrclk); #1;
      rst2_n = 1;
      for (int i = 0; i < 50 && !done; i++) begin
        @(negedge wrclk);
        if (init_busy2) n++; else done = 1;
        @(posedge wrclk); #1;
      end
      chk("init_len_aw3", 64'(n), 64'(8));
      regwr2 = 1; rw2 = 7; busW2 = 64'hFEDCBA9876543210; ra2 = 7; rb2 = 0;
      @(negedge wrclk);
      chk("aw3_bypass_a", busA2, 64'hFEDCBA9876543210);
      chk("aw3_zero_b", busB2, 64'h0);
      @(posedge wrclk); #1;
      regwr2 = 1; rw2 = 0; busW2 = '1; ra2 = 7; rb2 = 0;
      @(posedge wrclk); #1;
      regwr2 = 0;
      @(negedge wrclk);
      chk("aw3_read7", busA2, 64'hFEDCBA9876543210);
      chk("aw3_read0", busB2, 64'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's 2-read/1-write integer register file.
- Adds configurable data width and register count, a synchronous-reset clear sequencer, and write-to-read bypass.
- Adds a per-register pending-write scoreboard so the decode stage can stall on RAW hazards.
- Sits between decode (read addresses, issue) and writeback (write port) in the single-clock core.

Parameters:
- XLEN, 32, data width of each register and of busW/busA/busB.
- AW, 5, register address width; register count NREG = 2**AW.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never marked pending.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports and masks the matching busy flag.

Ports:
- wrclk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled at rising edge of wrclk.
- regwr  in  1  write enable from writeback.
- rw  in  AW  write address (rd).
- busW  in  XLEN  write data.
- ra  in  AW  read address A (rs1).
- rb  in  AW  read address B (rs2).
- busA  out  XLEN  read data A, combinational.
- busB  out  XLEN  read data B, combinational.
- issue_vld  in  1  decode issues an instruction that will write issue_rd.
- issue_rd  in  AW  destination of the issued instruction.
- busy_a  out  1  register ra has an outstanding write (stall).
- busy_b  out  1  register rb has an outstanding write (stall).
- init_busy  out  1  clear sequencer active; decode must not issue.

Behaviour:
- Reset (rst_n=0 at an edge):
  - init counter <= 0, init_busy <= 1.
  - All pending bits <= 0.
  - Array contents are not touched directly by reset.
  - Held reset keeps this state.
- Clear sequencer, FSM states INIT and RUN:
  - INIT: each edge with rst_n=1 writes 0 to reg[cnt], then cnt <= cnt+1.
  - After the edge that writes reg[NREG-1], go to RUN with init_busy <= 0.
  - INIT therefore lasts exactly NREG cycles after reset release.
  - rst_n=0 at any time, including mid-INIT or in RUN, restarts INIT from cnt=0.
- During INIT:
  - regwr and issue_vld are ignored.
  - busA, busB, busy_a, busy_b are all 0.
- Write (RUN): at the rising edge, if regwr=1 then reg[rw] <= busW. With ZERO_REG=1, writes to rw=0 are dropped.
- Read (RUN, combinational), for busA:
  - ZERO_REG and ra=0 -> 0.
  - Else if BYPASS and regwr and rw==ra (and rw!=0 when ZERO_REG) -> busW.
  - Else reg[ra].
  - busB follows the same rule with rb.
- Scoreboard (RUN), per register:
  - issue_vld sets pend[issue_rd] at the edge.
  - regwr clears pend[rw] at the edge.
  - Index 0 is never set when ZERO_REG=1.
  - Set and clear of the same index in the same cycle: set wins (the newer writer is outstanding).
  - Set and clear of different indices in the same cycle: both take effect.
- busy_a = pend[ra] AND NOT (BYPASS and regwr and rw==ra). busy_b is the same with rb.
- With BYPASS=0, busy follows pend only. Reads then see the old value in the write cycle and the new value from the next cycle.
- Latency: write visible to reads 0 cycles when bypassed, otherwise 1 cycle. Pending bit visible the cycle after issue.
- Widths: no arithmetic. Out-of-range addresses are impossible because NREG = 2**AW.

Test Plan:
- Reset/init (AW=5): hold rst_n=0 for 3 cycles, then release -> init_busy=1 for exactly 32 cycles, then 0. Every register reads 0. regwr with rw=5, busW=0xDEAD during INIT is ignored, so reg5 reads 0.
- Write/read: write rw=3, busW=0x12345678 in RUN, then ra=3 next cycle -> busA=0x12345678. Write rw=0, busW=0xFFFFFFFF, then ra=0 -> busA=0.
- Bypass: in one cycle regwr=1, rw=7, busW=0xA5A5A5A5, ra=rb=7 -> busA=busB=0xA5A5A5A5 in that cycle. With BYPASS=0 -> old value that cycle, new value the next.
- Scoreboard: issue_vld with issue_rd=9, then ra=9 next cycle -> busy_a=1. Writeback rw=9 in cycle N -> busy_a=0 in cycle N (bypass), pend cleared at N+1. Same-cycle issue_rd=9 and rw=9 -> busy_a=1 the following cycle.
- Reset mid-operation: pend[4]=1 and reg4=0x55; assert rst_n=0 for one cycle at cnt=10 of a running INIT or in RUN -> sequencer restarts at 0. After 32 cycles, reg4=0, busy_a=0 for ra=4, init_busy=0.
- Parameter sweep: XLEN=64, AW=3 -> INIT lasts 8 cycles, and write/read of 0xFEDCBA9876543210 to reg7 reads back exact.
